// File: rtl/switch_debounce8.sv
// switch_debounce8: sync + debounce of 8 slide switches and an enable switch.
// Optional macro STICKY_LATCH_EN: x bits latch on rise, cleared by clr.
module switch_debounce8 #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES+1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       sw_en,
  input  logic       clr,
  output logic [7:0] x,
  output logic       enable,
  output logic       changed
);

  localparam int N = 9;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES-1);

  logic [N-1:0]     s1;
  logic [N-1:0]     s2;
  logic [N-1:0]     q;
  logic [N-1:0]     q_n;
  logic [CNT_W-1:0] cnt   [N];
  logic [CNT_W-1:0] cnt_n [N];
  logic [7:0]       x_n;
  logic             changed_n;

  // two-flop synchroniser for all nine raw lines
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {sw_en, sw};
      s2 <= s1;
    end
  end

  // per-line debounce: count mismatching samples, follow after a full run
  always_comb begin
    q_n = q;
    for (int i = 0; i < N; i++) begin
      cnt_n[i] = '0;
      if (s2[i] != q[i]) begin
        if (cnt[i] == CNT_MAX) begin
          q_n[i] = s2[i];
        end else begin
          cnt_n[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // debounced level and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      q <= q_n;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_n[i];
      end
    end
  end

  assign enable = q[8];

`ifdef STICKY_LATCH_EN
  logic [7:0] x_r;

  // rising debounced bits set x; clr wipes it, set wins over clear
  always_comb begin
    x_n = x_r;
    if (clr) begin
      x_n = '0;
    end
    x_n = x_n | (q_n[7:0] & ~q[7:0]);
  end

  // latched switch vector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r <= '0;
    end else begin
      x_r <= x_n;
    end
  end

  assign x = x_r;
`else
  logic unused_clr;

  assign unused_clr = clr;

  // without latching the vector is the debounced level itself
  always_comb begin
    x_n = q_n[7:0];
  end

  assign x = q[7:0];
`endif

  // flag any difference between next and current output vector
  always_comb begin
    changed_n = ({q_n[8], x_n} != {q[8], x});
  end

  // one-cycle change pulse aligned with the output update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      changed <= 1'b0;
    end else begin
      changed <= changed_n;
    end
  end

endmodule

// File: doc/switch_debounce8.md
Name: switch_debounce8

Overview:
- Input conditioning stage that sits directly upstream of the 8-to-3 priority-encoder / 7-segment display path.
- Takes 8 raw slide-switch levels plus a raw enable switch from the board pins.
- Synchronises and debounces each of the 9 lines.
- Presents clean, glitch-free `x[7:0]` and `enable` levels to the encoder, plus a one-cycle `changed` pulse whenever the conditioned vector updates.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable samples required before a line's output follows its input. Legal range 1..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width. Derived; not overridden.

Ports:
- clk      input   1  system clock.
- rst_n    input   1  synchronous active-low reset.
- sw       input   8  raw switch levels, asynchronous to clk.
- sw_en    input   1  raw enable switch, asynchronous to clk.
- clr      input   1  sticky-latch clear pulse; ignored unless STICKY_LATCH_EN is defined.
- x        output  8  debounced switch vector to the encoder.
- enable   output  1  debounced enable to the encoder.
- changed  output  1  single-cycle pulse: `{enable,x}` differs from its previous-cycle value.

Behaviour:
- Reset:
  - Sampled only on rising clk with rst_n==0.
  - At that edge, clears synchroniser flops, counters, `x`, `enable` and `changed` to 0.
  - Reset asserted mid-debounce discards the partial count.
  - No output change is produced by the reset itself; `changed` stays 0 in the cycle reset releases.
- Synchroniser:
  - Each of the 9 raw lines passes through 2 flops (`s1` then `s2`).
  - Only `s2` is used downstream.
- Debounce, per line, independent of the others, keeping `cnt[CNT_W-1:0]` and output bit `q`:
  - If `s2 == q`: `cnt <= 0`.
  - If `s2 != q` and `cnt == DEBOUNCE_CYCLES-1`: `q <= s2`, `cnt <= 0`.
  - If `s2 != q` otherwise: `cnt <= cnt+1`.
  - An input pulse or glitch shorter than DEBOUNCE_CYCLES samples restarts the count and never reaches `q`.
- Latency:
  - Raw level settled before edge E appears on the output after edge E+1+DEBOUNCE_CYCLES, i.e. 2+DEBOUNCE_CYCLES edges.
  - This is 6 edges at the default.
- DEBOUNCE_CYCLES==1: a single mismatching `s2` sample updates `q`, so latency is 3 edges.
- `changed`:
  - Registered at the same edge `x`/`enable` update.
  - High for exactly one cycle when any bit of `{enable,x}` changed at that edge.
  - Simultaneous changes on several lines produce a single pulse.
  - Changes on consecutive edges produce consecutive pulses.
- Outputs are all registered; there is no combinational path from the `sw`/`sw_en`/`clr` inputs to the outputs.
- Counter never wraps: its maximum value is DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: STICKY_LATCH_EN.
- Defined:
  - Each `x[i]` sets when its debounced bit `q[i]` rises, and stays set after the switch drops.
  - All `x` bits clear on the edge where `clr==1`.
  - A bit whose `q` rises in the same cycle as `clr` ends set (set wins).
  - `enable` is never sticky.
  - `changed` reflects changes of the latched `x`, including a clear.
- Undefined:
  - `x == q` directly.
  - `clr` is ignored with no logic behind it; the port still exists.

Test Plan:
- Reset:
  - Drive `sw=8'hFF`, `sw_en=1`, `rst_n=0` for 3 edges → `x==0`, `enable==0`, `changed==0`.
  - Release reset → `x==8'hFF`, `enable==1` and `changed==1` appear together exactly 6 edges later, with `changed` high one cycle.
- Latency (DEBOUNCE_CYCLES=4):
  - From `sw=0`, set `sw=8'h20` before edge E → `x` remains 0 through edge E+4 and becomes `8'h20` after edge E+5.
  - `changed` pulses only in that cycle.
- Glitch rejection:
  - Pulse `sw[3]` high for 3 cycles, then low → `x` stays 0 and `changed` never asserts.
  - Repeat with a 4-cycle pulse → `x[3]` goes high then low, and `changed` pulses twice.
- Simultaneous / independent lines:
  - `sw` 0→`8'h81` on one edge → a single `changed` pulse with `x==8'h81`.
  - Then toggle `sw[0]` for 2 cycles while `sw[7]` stays high → `x` holds `8'h81`.
- Reset mid-operation:
  - Set `sw=8'h01`, assert `rst_n=0` at edge E+3, release at E+4 → `x==0` at E+4.
  - The full 6-edge latency restarts from release.
- Sticky (STICKY_LATCH_EN):
  - Debounced `sw[5]` pulse → `x==8'h20` persists after `sw` returns to 0.
  - `clr=1` for one cycle → `x==0` with a `changed` pulse.
  - `clr` coincident with `q[2]` rising → `x==8'h04`.
